// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - register file read/write/issue bus between decode, writeback and reg_file_sb
//
// Purpose: bundles the read ports, both write ports, the issue port and the
// scoreboard status outputs of reg_file_sb into one interface.
// Signals (all widths follow DW/DEPTH/NUM_RD, AW = $clog2(DEPTH)):
//   RF_rd_addr   NUM_RD*AW  read addresses, port k at [k*AW +: AW]
//   RF_rd_data   NUM_RD*DW  read data, port k at [k*DW +: DW]
//   RF_rd_busy   NUM_RD     addressed register still owned by an in-flight op
//   RF_wr0_*               pipeline writeback port
//   RF_wr1_*               long-latency unit write port (clears pending)
//   RF_issue_*             marks a destination register pending
//   RF_pend_cnt  AW+1       number of pending registers
//   RF_err       1          sticky scoreboard protocol error
// Modports: master = decode/writeback side, slave = register file.
interface reg_file_sb_if #(
  parameter int DW     = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_RD*AW-1:0] RF_rd_addr;
  logic [NUM_RD*DW-1:0] RF_rd_data;
  logic [NUM_RD-1:0]    RF_rd_busy;
  logic                 RF_wr0_en;
  logic [AW-1:0]        RF_wr0_addr;
  logic [DW-1:0]        RF_wr0_data;
  logic                 RF_wr1_en;
  logic [AW-1:0]        RF_wr1_addr;
  logic [DW-1:0]        RF_wr1_data;
  logic                 RF_issue_en;
  logic [AW-1:0]        RF_issue_addr;
  logic [AW:0]          RF_pend_cnt;
  logic                 RF_err;

  modport master (
    output RF_rd_addr, RF_wr0_en, RF_wr0_addr, RF_wr0_data,
           RF_wr1_en, RF_wr1_addr, RF_wr1_data, RF_issue_en, RF_issue_addr,
    input  RF_rd_data, RF_rd_busy, RF_pend_cnt, RF_err
  );

  modport slave (
    input  RF_rd_addr, RF_wr0_en, RF_wr0_addr, RF_wr0_data,
           RF_wr1_en, RF_wr1_addr, RF_wr1_data, RF_issue_en, RF_issue_addr,
    output RF_rd_data, RF_rd_busy, RF_pend_cnt, RF_err
  );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-read, dual-write register file with per-register pending scoreboard
//
// Purpose: NUM_RD combinational read ports, a pipeline write port (wr0) and a
// long-latency write port (wr1). Each register carries a pending bit set by
// issue and cleared by wr1, so decode can stall on operands still in flight.
// Ports:
//   clk        rising-edge clock
//   SYS_reset  asynchronous active-high reset; clears array and scoreboard
//   bus        reg_file_sb_if.slave (read/write/issue ports, busy, pend_cnt, err)
// Optional build macro: REGFILE_BYPASS_EN - reads forward same-cycle write data
// (wr1 over wr0); otherwise reads return the pre-edge array content.
module reg_file_sb #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         SYS_reset,
  reg_file_sb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [AW:0]      r_pend_cnt;
  logic             r_err;

  logic w_wr0_ok, w_wr1_ok, w_iss_ok, w_same;
  logic w_iss_err, w_wr1_err, w_inc, w_dec;

  function automatic logic f_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Operations aimed at the hard-wired zero register are silently dropped.
  assign w_wr0_ok = bus.RF_wr0_en   & ~f_zero(bus.RF_wr0_addr);
  assign w_wr1_ok = bus.RF_wr1_en   & ~f_zero(bus.RF_wr1_addr);
  assign w_iss_ok = bus.RF_issue_en & ~f_zero(bus.RF_issue_addr);
  assign w_same   = (bus.RF_wr1_addr == bus.RF_issue_addr);

  // A completion and a new issue to the same register hand ownership over
  // cleanly: neither side is an error and the bit stays set.
  assign w_iss_err = w_iss_ok & r_pend[bus.RF_issue_addr] & ~(w_wr1_ok & w_same);
  assign w_wr1_err = w_wr1_ok & ~r_pend[bus.RF_wr1_addr] & ~(w_iss_ok & w_same);

  // Population count is tracked incrementally from the bits that actually flip.
  assign w_inc = w_iss_ok & ~r_pend[bus.RF_issue_addr];
  assign w_dec = w_wr1_ok & r_pend[bus.RF_wr1_addr] & ~(w_iss_ok & w_same);

  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_pend     <= '0;
      r_pend_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_wr0_ok) begin
        r_mem[bus.RF_wr0_addr] <= bus.RF_wr0_data;
      end
      // Later assignment wins: wr1 data over wr0, issue set over wr1 clear.
      if (w_wr1_ok) begin
        r_mem[bus.RF_wr1_addr]  <= bus.RF_wr1_data;
        r_pend[bus.RF_wr1_addr] <= 1'b0;
      end
      if (w_iss_ok) begin
        r_pend[bus.RF_issue_addr] <= 1'b1;
      end
      r_pend_cnt <= r_pend_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
      if (w_iss_err || w_wr1_err) begin
        r_err <= 1'b1;
      end
    end
  end

  logic [NUM_RD*DW-1:0] w_rd_data;
  logic [NUM_RD-1:0]    w_rd_busy;
  logic [AW-1:0]        w_ra;
  logic [DW-1:0]        w_rd;

  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    w_ra      = '0;
    w_rd      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_ra = bus.RF_rd_addr[k*AW +: AW];
      w_rd = r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
      if (w_wr1_ok && (bus.RF_wr1_addr == w_ra)) begin
        w_rd = bus.RF_wr1_data;
      end else if (w_wr0_ok && (bus.RF_wr0_addr == w_ra)) begin
        w_rd = bus.RF_wr0_data;
      end
`endif
      if (f_zero(w_ra)) begin
        w_rd = '0;
      end
      w_rd_data[k*DW +: DW] = w_rd;
      // A completing wr1 releases the operand in the same cycle.
      w_rd_busy[k] = r_pend[w_ra] & ~(bus.RF_wr1_en & (bus.RF_wr1_addr == w_ra));
    end
  end

  assign bus.RF_rd_data  = w_rd_data;
  assign bus.RF_rd_busy  = w_rd_busy;
  assign bus.RF_pend_cnt = r_pend_cnt;
  assign bus.RF_err      = r_err;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb with random and directed stimulus
module tb_reg_file_sb;
  localparam int DW     = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  logic clk = 1'b0;
  logic SYS_reset;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus ();

  reg_file_sb #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1)) dut (
    .clk       (clk),
    .SYS_reset (SYS_reset),
    .bus       (bus.slave)
  );

  typedef struct {
    logic [NUM_RD*DW-1:0] data;
    logic [NUM_RD-1:0]    busy;
    logic [AW:0]          cnt;
    logic                 err;
    string                tag;
  } exp_t;

  exp_t q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: plain arrays following the architectural rules.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend[DEPTH];
  bit            m_err;
  bit            rst_pending;

  // Currently driven stimulus (tb-side copy).
  bit            s_w0e, s_w1e, s_ie;
  int            s_w0a, s_w1a, s_ia;
  logic [DW-1:0] s_w0d, s_w1d;
  int            s_rd[NUM_RD];

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_err = 1'b0;
  endfunction

  // Effect of one rising edge with the stimulus that was held during the cycle.
  function automatic void model_commit();
    bit w1ok = s_w1e && (s_w1a != 0);
    bit iok  = s_ie && (s_ia != 0);
    if (iok && m_pend[s_ia] && !(w1ok && s_w1a == s_ia)) m_err = 1'b1;
    if (w1ok && !m_pend[s_w1a] && !(iok && s_ia == s_w1a)) m_err = 1'b1;
    if (s_w0e && s_w0a != 0) m_mem[s_w0a] = s_w0d;
    if (w1ok) begin
      m_mem[s_w1a]  = s_w1d;
      m_pend[s_w1a] = 1'b0;
    end
    if (iok) m_pend[s_ia] = 1'b1;
  endfunction

  function automatic void push_expected(input string tag);
    exp_t e;
    int cnt = 0;
    e.data = '0;
    e.busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      int a = s_rd[k];
      logic [DW-1:0] d = m_mem[a];
`ifdef REGFILE_BYPASS_EN
      if (s_w1e && s_w1a == a) d = s_w1d;
      else if (s_w0e && s_w0a == a) d = s_w0d;
`endif
      if (a == 0) d = '0;
      e.data[k*DW +: DW] = d;
      e.busy[k] = (a != 0) && m_pend[a] && !(s_w1e && s_w1a == a);
    end
    for (int i = 0; i < DEPTH; i++) cnt += int'(m_pend[i]);
    e.cnt = (AW+1)'(cnt);
    e.err = m_err;
    e.tag = tag;
    q.push_back(e);
  endfunction

  function automatic void apply_bus();
    bus.RF_wr0_en     = s_w0e;
    bus.RF_wr0_addr   = AW'(s_w0a);
    bus.RF_wr0_data   = s_w0d;
    bus.RF_wr1_en     = s_w1e;
    bus.RF_wr1_addr   = AW'(s_w1a);
    bus.RF_wr1_data   = s_w1d;
    bus.RF_issue_en   = s_ie;
    bus.RF_issue_addr = AW'(s_ia);
    for (int k = 0; k < NUM_RD; k++) bus.RF_rd_addr[k*AW +: AW] = AW'(s_rd[k]);
  endfunction

  task automatic drive(input bit w0e, input int w0a, input logic [DW-1:0] w0d,
                       input bit w1e, input int w1a, input logic [DW-1:0] w1d,
                       input bit ie, input int ia, input int r0, input int r1,
                       input string tag);
    @(posedge clk);
    #1;
    if (rst_pending) begin
      SYS_reset   = 1'b0;
      rst_pending = 1'b0;
    end else begin
      model_commit();
    end
    s_w0e = w0e; s_w0a = w0a; s_w0d = w0d;
    s_w1e = w1e; s_w1a = w1a; s_w1d = w1d;
    s_ie  = ie;  s_ia  = ia;
    s_rd[0] = r0; s_rd[1] = r1;
    apply_bus();
    push_expected(tag);
  endtask

  task automatic idle(input int r0, input int r1, input string tag);
    drive(0, 0, '0, 0, 0, '0, 0, 0, r0, r1, tag);
  endtask

  // Reset asserted between clock edges; outputs must clear before the next edge.
  task automatic reset_mid(input int r0, input int r1, input string tag);
    @(posedge clk);
    #1;
    if (!rst_pending) model_commit();
    s_w0e = 0; s_w1e = 0; s_ie = 0;
    s_w0a = 0; s_w1a = 0; s_ia = 0;
    s_w0d = '0; s_w1d = '0;
    s_rd[0] = r0; s_rd[1] = r1;
    apply_bus();
    #2;
    SYS_reset   = 1'b1;
    rst_pending = 1'b1;
    model_clear();
    push_expected(tag);
  endtask

  task automatic check(input string tag, input string what, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got=%h exp=%h t=%0t", tag, what, got, exp, $time);
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.tag, "rd_data", 64'(bus.RF_rd_data), 64'(e.data));
      check(e.tag, "rd_busy", 64'(bus.RF_rd_busy), 64'(e.busy));
      check(e.tag, "pend_cnt", 64'(bus.RF_pend_cnt), 64'(e.cnt));
      check(e.tag, "err", 64'(bus.RF_err), 64'(e.err));
    end
  end

  initial begin
    SYS_reset   = 1'b1;
    rst_pending = 1'b1;
    model_clear();
    s_w0e = 0; s_w1e = 0; s_ie = 0;
    s_w0a = 0; s_w1a = 0; s_ia = 0;
    s_w0d = '0; s_w1d = '0;
    s_rd[0] = 0; s_rd[1] = 0;
    apply_bus();
    repeat (2) @(posedge clk);

    for (int i = 0; i < DEPTH; i += 2) idle(i, i + 1, "reset_scan");

    drive(1, 5, 32'hDEADBEEF, 0, 0, '0, 0, 0, 5, 5, "wr0_r5_same");
    idle(0, 5, "rd_r5");
    drive(1, 0, 32'h1234, 0, 0, '0, 0, 0, 0, 5, "wr0_r0");
    idle(0, 0, "rd_r0");

    drive(0, 0, '0, 0, 0, '0, 1, 7, 7, 7, "iss_r7");
    drive(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 7, "wr01_r7");
    idle(7, 7, "rd_r7");

    drive(0, 0, '0, 0, 0, '0, 1, 9, 9, 9, "iss_r9");
    idle(9, 1, "busy_r9");
    drive(0, 0, '0, 1, 9, 32'hABCD, 0, 0, 9, 9, "wr1_r9");
    idle(9, 9, "rd_r9");
    drive(0, 0, '0, 0, 0, '0, 1, 9, 9, 0, "reiss_r9");
    drive(0, 0, '0, 0, 0, '0, 1, 9, 9, 0, "dbliss_r9");
    idle(9, 9, "err_sticky");
    idle(9, 9, "err_sticky2");

    drive(1, 3, 32'h55, 0, 0, '0, 0, 0, 3, 3, "wr0_r3_bypass");
    idle(3, 3, "rd_r3");

    drive(0, 0, '0, 0, 0, '0, 1, 4, 4, 6, "iss_r4");
    drive(0, 0, '0, 0, 0, '0, 1, 6, 4, 6, "iss_r6");
    reset_mid(4, 6, "mid_reset");
    drive(0, 0, '0, 1, 4, 32'h77, 0, 0, 4, 6, "wr1_after_rst");
    idle(4, 6, "err_after_rst");

    for (int n = 0; n < 2000; n++) begin
      bit w0e = ($urandom_range(0, 2) != 0);
      bit w1e = ($urandom_range(0, 3) == 0);
      bit ie  = ($urandom_range(0, 3) == 0);
      int w0a = $urandom_range(0, DEPTH - 1);
      int w1a = $urandom_range(0, DEPTH - 1);
      int ia  = $urandom_range(0, DEPTH - 1);
      int r0  = $urandom_range(0, DEPTH - 1);
      int r1  = $urandom_range(0, DEPTH - 1);
      int pl[$];
      for (int i = 0; i < DEPTH; i++) if (m_pend[i]) pl.push_back(i);
      if (pl.size() > 0 && $urandom_range(0, 3) != 0) w1a = pl[$urandom_range(0, pl.size() - 1)];
      if ($urandom_range(0, 3) == 0) r0 = w0a;
      if ($urandom_range(0, 3) == 0) r1 = w1a;
      if ($urandom_range(0, 7) == 0) ia = w1a;
      if (n == 1000) reset_mid(r0, r1, "rand_reset");
      else drive(w0e, w0a, DW'($urandom), w1e, w1a, DW'($urandom), ie, ia, r0, r1, "rand");
    end

    @(posedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d exp=0 entries left", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
